// File: rtl/fir_l3_serializer.sv
// Parallel-to-serial output stage for the L-parallel FIR datapath: buffers up to DEPTH blocks of
// LANES samples and streams them out one sample per cycle, oldest lane first.
module fir_l3_serializer #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LANES      = 3,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]                 in_data,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DATA_WIDTH-1:0]                       out_data,
   output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] out_lane,
   output logic                                        out_last
);

   localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(DEPTH + 1);

   localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);
   localparam logic [PtrW-1:0]  LastPtr  = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0]  FullCnt  = CntW'(DEPTH);

   logic [LANES*DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [LaneW-1:0] lane_q, lane_d;

   logic                        push, pop, free_blk;
   logic [LANES*DATA_WIDTH-1:0] head_blk;
   logic [DATA_WIDTH-1:0]       head_sample;

   // reset_n gating keeps in_ready low during reset; no path from in_valid or out_ready.
   assign in_ready  = reset_n && (count_q < FullCnt);
   assign out_valid = (count_q != '0);

   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign free_blk = pop && (lane_q == LastLane);

   assign head_blk = mem_q[rd_ptr_q];

   always_comb begin
      head_sample = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (lane_q == LaneW'(k)) begin
            head_sample = head_blk[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign out_data = out_valid ? head_sample : '0;
   assign out_lane = out_valid ? lane_q : '0;
   assign out_last = out_valid && (lane_q == LastLane);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      lane_d   = lane_q;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end

      if (pop) begin
         if (lane_q == LastLane) begin
            lane_d   = '0;
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
         end else begin
            lane_d = lane_q + LaneW'(1);
         end
      end

      case ({push, free_blk})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         lane_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         lane_q   <= lane_d;
      end
   end

   // Payload storage needs no reset: out_data is masked whenever count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_fir_l3_serializer.sv
// Directed bench for fir_l3_serializer: a DEPTH=2 and a DEPTH=1 instance share the inputs,
// and each scenario task checks the selected instance against hand-computed values.
module tb_fir_l3_serializer;

   localparam int unsigned DW = 64;
   localparam int unsigned L  = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          in_valid = 1'b0;
   logic [L*DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;

   logic          in_ready0, out_valid0, out_last0;
   logic [DW-1:0] out_data0;
   logic [1:0]    out_lane0;
   logic          in_ready1, out_valid1, out_last1;
   logic [DW-1:0] out_data1;
   logic [1:0]    out_lane1;

   logic          sel = 1'b0;
   logic          cur_in_ready, cur_out_valid, cur_out_last;
   logic [DW-1:0] cur_out_data;
   logic [1:0]    cur_out_lane;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   fir_l3_serializer #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(2)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_lane(out_lane0), .out_last(out_last0)
   );

   fir_l3_serializer #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_lane(out_lane1), .out_last(out_last1)
   );

   assign cur_in_ready  = sel ? in_ready1  : in_ready0;
   assign cur_out_valid = sel ? out_valid1 : out_valid0;
   assign cur_out_last  = sel ? out_last1  : out_last0;
   assign cur_out_data  = sel ? out_data1  : out_data0;
   assign cur_out_lane  = sel ? out_lane1  : out_lane0;

   function automatic logic [L*DW-1:0] blk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
      return {c, b, a};
   endfunction

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      total_cnt++;
      if (cur_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b exp 0", cur_out_valid);
      else pass_cnt++;
      total_cnt++;
      if (cur_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b exp 0", cur_in_ready);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      total_cnt++;
      if (cur_in_ready !== 1'b1) $display("FAIL release_in_ready: got %0b exp 1", cur_in_ready);
      else pass_cnt++;
      // Build count=2, lane=1 then reset mid-block.
      @(negedge clk);
      in_valid = 1'b1; in_data = blk(64'd100, 64'd101, 64'd102);
      @(negedge clk);
      in_data = blk(64'd110, 64'd111, 64'd112); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      total_cnt++;
      if (cur_out_data !== 64'd101 || cur_out_lane !== 2'd1)
         $display("FAIL midstream_pre: got %0d/%0d exp 101/1", cur_out_data, cur_out_lane);
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({cur_out_valid, cur_out_last, cur_out_lane, cur_out_data, cur_in_ready} !== '0)
         $display("FAIL midstream_reset: got v=%0b d=%0h ln=%0d lst=%0b rdy=%0b exp all 0",
                  cur_out_valid, cur_out_data, cur_out_lane, cur_out_last, cur_in_ready);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1; out_ready = 1'b1;
      #1;
      total_cnt++;
      if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0)
         $display("FAIL midstream_release: got rdy=%0b v=%0b exp 1/0", cur_in_ready,
                  cur_out_valid);
      else pass_cnt++;
      begin
         int seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (cur_out_valid) seen++;
         end
         total_cnt++;
         if (seen != 0) $display("FAIL no_partial_after_reset: got %0d valid cycles exp 0", seen);
         else pass_cnt++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_single();
      sel = 1'b0;
      do_reset();
      in_valid = 1'b1; in_data = blk(64'd1, 64'd2, 64'd3); out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         total_cnt++;
         if (cur_out_valid !== 1'b1 || cur_out_data !== DW'(i + 1) || cur_out_lane !== 2'(i) ||
             cur_out_last !== (i == 2))
            $display("FAIL single_lane%0d: got v=%0b d=%0d ln=%0d lst=%0b exp 1/%0d/%0d/%0b", i,
                     cur_out_valid, cur_out_data, cur_out_lane, cur_out_last, i + 1, i, i == 2);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if (cur_out_valid !== 1'b0 || cur_out_data !== '0)
         $display("FAIL single_after: got v=%0b d=%0h exp 0/0", cur_out_valid, cur_out_data);
      else pass_cnt++;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back(input bit use_d1, input int exp_gaps);
      logic [DW-1:0] exp_s [9];
      int nb = 0, got = 0, gaps = 0, mcnt = 0, depth;
      bit started = 0;
      bit pushed, freed;
      depth = use_d1 ? 1 : 2;
      for (int b = 0; b < 3; b++)
         for (int k = 0; k < 3; k++) exp_s[b*3+k] = DW'(10 * (b + 1) + k);
      sel = use_d1;
      do_reset();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 9; cyc++) begin
         @(negedge clk);
         freed = 1'b0;
         total_cnt++;
         if (cur_in_ready !== (mcnt < depth))
            $display("FAIL b2b_d%0d_in_ready cyc%0d: got %0b exp %0b", depth, cyc, cur_in_ready,
                     mcnt < depth);
         else pass_cnt++;
         if (cur_out_valid) begin
            started = 1;
            total_cnt++;
            if (cur_out_data !== exp_s[got] || cur_out_last !== (got % 3 == 2))
               $display("FAIL b2b_d%0d_sample%0d: got %0d lst=%0b exp %0d lst=%0b", depth, got,
                        cur_out_data, cur_out_last, exp_s[got], got % 3 == 2);
            else pass_cnt++;
            got++;
            freed = (got % 3 == 0);
         end else if (started) begin
            gaps++;
         end
         pushed = (mcnt < depth) && (nb < 3);
         if (pushed) begin
            in_valid = 1'b1;
            in_data  = blk(DW'(10 * (nb + 1)), DW'(10 * (nb + 1) + 1), DW'(10 * (nb + 1) + 2));
            nb++;
         end else begin
            in_valid = 1'b0;
         end
         mcnt = mcnt + int'(pushed) - int'(freed);
      end
      in_valid = 1'b0;
      total_cnt++;
      if (got != 9) $display("FAIL b2b_d%0d_count: got %0d samples exp 9", depth, got);
      else pass_cnt++;
      total_cnt++;
      if (gaps != exp_gaps) $display("FAIL b2b_d%0d_gaps: got %0d exp %0d", depth, gaps, exp_gaps);
      else pass_cnt++;
      out_ready = 1'b0;
      sel = 1'b0;
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      do_reset();
      in_valid = 1'b1; in_data = blk(64'd40, 64'd41, 64'd42);
      @(negedge clk);
      in_data = blk(64'd50, 64'd51, 64'd52);
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++;
      if (cur_in_ready !== 1'b0 || cur_out_data !== 64'd40)
         $display("FAIL bp_full: got rdy=%0b d=%0d exp 0/40", cur_in_ready, cur_out_data);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (cur_out_data !== 64'd40 || cur_out_lane !== 2'd0 || cur_out_valid !== 1'b1)
         $display("FAIL bp_hold: got d=%0d ln=%0d v=%0b exp 40/0/1", cur_out_data, cur_out_lane,
                  cur_out_valid);
      else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (cur_out_data !== 64'd41 || cur_in_ready !== 1'b0)
         $display("FAIL bp_lane1: got d=%0d rdy=%0b exp 41/0", cur_out_data, cur_in_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (cur_out_data !== 64'd42 || cur_out_last !== 1'b1 || cur_in_ready !== 1'b0)
         $display("FAIL bp_last: got d=%0d lst=%0b rdy=%0b exp 42/1/0", cur_out_data,
                  cur_out_last, cur_in_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (cur_in_ready !== 1'b1 || cur_out_data !== 64'd50)
         $display("FAIL bp_freed: got rdy=%0b d=%0d exp 1/50", cur_in_ready, cur_out_data);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (cur_out_data !== 64'd52 || cur_out_last !== 1'b1)
         $display("FAIL bp_drain: got d=%0d lst=%0b exp 52/1", cur_out_data, cur_out_last);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (cur_out_valid !== 1'b0) $display("FAIL bp_empty: got v=%0b exp 0", cur_out_valid);
      else pass_cnt++;
      out_ready = 1'b0;
   endtask

   task automatic test_full_width();
      logic [DW-1:0] v [3];
      v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      v[1] = 64'h7FFF_FFFF_FFFF_FFFF;
      v[2] = 64'h8000_0000_0000_0000;
      sel = 1'b0;
      do_reset();
      in_valid = 1'b1; in_data = blk(v[0], v[1], v[2]); out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         total_cnt++;
         if (cur_out_data !== v[i])
            $display("FAIL full_width_lane%0d: got %h exp %h", i, cur_out_data, v[i]);
         else pass_cnt++;
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back(1'b0, 0);
      test_backpressure();
      test_full_width();
      test_back_to_back(1'b1, 2);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "timeout");
   end

endmodule
